// File: rtl/chip8_timebase.sv
// Phase-accumulator clock-enable generator with an edge-triggered,
// tick-stretched system reset sequencer.
module chip8_timebase #(
  parameter int NUM_CH    = 3,
  parameter int ACC_W     = 32,
  parameter int NUM_SRC   = 3,
  parameter int RST_TICKS = 16
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic [NUM_CH*ACC_W-1:0] ch_inc,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic                    sync_clr,
  output logic [NUM_CH-1:0]       ce,
  input  logic [NUM_SRC-1:0]      req_rise,
  input  logic                    req_fall,
  output logic                    sys_reset,
  output logic                    rst_trig
);

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } state_e;

  localparam logic [7:0] LAST = 8'(RST_TICKS - 1);

  logic [ACC_W-1:0]   acc_q [NUM_CH];
  logic [ACC_W-1:0]   acc_d [NUM_CH];
  logic [ACC_W:0]     sum   [NUM_CH];
  logic [NUM_CH-1:0]  ce_q;
  logic [NUM_CH-1:0]  ce_d;

  logic [NUM_SRC-1:0] rise_prev_q;
  logic               fall_prev_q;
  logic               trig;

  state_e             state_q;
  state_e             state_d;
  logic [7:0]         cnt_q;
  logic [7:0]         cnt_d;
  logic               sys_reset_q;
  logic               rst_trig_q;

  // The carry out of each add is the enable pulse for that channel.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sum[i]   = {1'b0, acc_q[i]}
               + {1'b0, ch_inc[i*ACC_W +: ACC_W]};
      acc_d[i] = acc_q[i];
      ce_d[i]  = 1'b0;
      if (sync_clr) begin
        acc_d[i] = '0;
      end else if (ch_en[i]) begin
        acc_d[i] = sum[i][ACC_W-1:0];
        ce_d[i]  = sum[i][ACC_W];
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      acc_q <= '{default: '0};
      ce_q  <= '0;
    end else begin
      acc_q <= acc_d;
      ce_q  <= ce_d;
    end
  end

  assign trig = (|(req_rise & ~rise_prev_q))
              | (~req_fall & fall_prev_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (trig) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        // A retrigger outranks the exit tick in the same cycle.
        if (trig) begin
          cnt_d = '0;
        end else if (ce_q[0]) begin
          if (cnt_q == LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    rise_prev_q <= req_rise;
    fall_prev_q <= req_fall;
    if (reset) begin
      state_q     <= ST_HOLD;
      cnt_q       <= '0;
      sys_reset_q <= 1'b1;
      rst_trig_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sys_reset_q <= (state_d == ST_HOLD);
      rst_trig_q  <= trig;
    end
  end

  assign ce        = ce_q;
  assign sys_reset = sys_reset_q;
  assign rst_trig  = rst_trig_q;

endmodule

// File: tb/tb_chip8_timebase.sv
// Scoreboard bench for chip8_timebase: a cycle model predicts ce,
// sys_reset and rst_trig for every edge; scenario tasks add totals.
module tb_chip8_timebase;

  localparam int NCH  = 3;
  localparam int AW   = 8;
  localparam int NSRC = 3;
  localparam int RSTT = 16;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic [NCH*AW-1:0] ch_inc;
  logic [NCH-1:0]    ch_en;
  logic              sync_clr;
  logic [NCH-1:0]    ce;
  logic [NSRC-1:0]   req_rise;
  logic              req_fall;
  logic              sys_reset;
  logic              rst_trig;

  chip8_timebase #(
    .NUM_CH(NCH), .ACC_W(AW), .NUM_SRC(NSRC), .RST_TICKS(RSTT)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ch_inc(ch_inc),
    .ch_en(ch_en), .sync_clr(sync_clr), .ce(ce),
    .req_rise(req_rise), .req_fall(req_fall),
    .sys_reset(sys_reset), .rst_trig(rst_trig)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [NCH-1:0] ce;
    logic           sr;
    logic           rt;
  } exp_t;

  exp_t sb_q[$];
  int vectors = 0;
  int miscompares = 0;

  int            m_acc [NCH];
  logic [NCH-1:0] m_ce;
  bit            m_hold;
  int            m_cnt;
  logic [NSRC-1:0] m_prise;
  logic          m_pfall;

  task automatic step();
    exp_t e;
    exp_t g;
    bit trig;
    int s;
    logic [NCH-1:0] nce;
    nce  = '0;
    trig = 0;
    if (reset) begin
      for (int i = 0; i < NCH; i++) m_acc[i] = 0;
      m_hold = 1;
      m_cnt  = 0;
    end else begin
      trig = ((req_rise & ~m_prise) != 0) || (!req_fall && m_pfall);
      if (!m_hold) begin
        if (trig) begin m_hold = 1; m_cnt = 0; end
      end else if (trig) begin
        m_cnt = 0;
      end else if (m_ce[0]) begin
        m_cnt++;
        if (m_cnt == RSTT) m_hold = 0;
      end
      for (int i = 0; i < NCH; i++) begin
        if (sync_clr) begin
          m_acc[i] = 0;
        end else if (ch_en[i]) begin
          s = m_acc[i] + int'(ch_inc[i*AW +: AW]);
          nce[i] = (s >= (1 << AW));
          m_acc[i] = s % (1 << AW);
        end
      end
    end
    m_prise = req_rise;
    m_pfall = req_fall;
    m_ce    = nce;
    e.ce = nce; e.sr = m_hold; e.rt = trig;
    sb_q.push_back(e);
    @(posedge clk_sys);
    #1;
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty t=%0t", $time);
    end else begin
      e = sb_q.pop_front();
      g.ce = ce; g.sr = sys_reset; g.rt = rst_trig;
      if (g !== e) begin
        miscompares++;
        $display("FAIL scoreboard t=%0t got ce=%b sr=%b rt=%b want ce=%b sr=%b rt=%b",
                 $time, g.ce, g.sr, g.rt, e.ce, e.sr, e.rt);
      end
    end
  endtask

  task automatic test_reset();
    ch_inc   = {8'd0, 8'd85, 8'd64};
    ch_en    = 3'b111;
    sync_clr = 1'b1;
    req_rise = 3'b111;
    reset    = 1'b1;
    req_fall = 1'b1; step();
    req_fall = 1'b0; step();
    req_fall = 1'b1; step();
    vectors++;
    if ({ce, sys_reset, rst_trig} !== {3'b000, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state got ce=%b sr=%b rt=%b want 000/1/0",
               ce, sys_reset, rst_trig);
    end
    sync_clr = 1'b0;
    reset    = 1'b0;
  endtask

  task automatic test_power_on();
    int first0 = 0, c0 = 0, c1 = 0, c2 = 0;
    int last1 = 0, bad_iv = 0, rts = 0, sr_fall = 0;
    for (int n = 1; n <= 256; n++) begin
      step();
      if (ce[0]) begin c0++; if (first0 == 0) first0 = n; end
      if (ce[1]) begin
        c1++;
        if (last1 != 0 && (n - last1 < 3 || n - last1 > 4)) bad_iv++;
        last1 = n;
      end
      if (ce[2]) c2++;
      if (rst_trig) rts++;
      if (sys_reset === 1'b0 && sr_fall == 0) sr_fall = n;
    end
    vectors++;
    if (first0 != 4) begin miscompares++;
      $display("FAIL first_ce0 got %0d want 4", first0); end
    vectors++;
    if (c0 != 64) begin miscompares++;
      $display("FAIL ce0_count got %0d want 64", c0); end
    vectors++;
    if (c1 != 85) begin miscompares++;
      $display("FAIL ce1_count got %0d want 85", c1); end
    vectors++;
    if (c2 != 0) begin miscompares++;
      $display("FAIL ce2_zero_inc got %0d want 0", c2); end
    vectors++;
    if (bad_iv != 0) begin miscompares++;
      $display("FAIL ce1_interval got %0d bad want 0", bad_iv); end
    vectors++;
    if (rts != 0) begin miscompares++;
      $display("FAIL held_src_trig got %0d want 0", rts); end
    vectors++;
    if (sr_fall != 65) begin miscompares++;
      $display("FAIL poweron_release got %0d want 65", sr_fall); end
  endtask

  task automatic test_full_rate();
    int c0 = 0, c2 = 0;
    ch_inc[23:16] = 8'd255;
    ch_inc[15:8]  = 8'd1;
    for (int n = 1; n <= 256; n++) begin
      step();
      if (ce[0]) c0++;
      if (ce[2]) c2++;
    end
    vectors++;
    if (c2 != 255) begin miscompares++;
      $display("FAIL ce2_full_rate got %0d want 255", c2); end
    vectors++;
    if (c0 != 64) begin miscompares++;
      $display("FAIL ce0_steady got %0d want 64", c0); end
  endtask

  task automatic test_retrigger();
    int ticks = 0, rts = 0, cyc = 0;
    bit retrig = 0;
    req_rise = 3'b011;
    step();
    vectors++;
    if (sys_reset !== 1'b0 || rst_trig !== 1'b0) begin miscompares++;
      $display("FAIL rise_src_drop got sr=%b rt=%b want 0/0",
               sys_reset, rst_trig); end
    req_fall = 1'b0;
    step();
    vectors++;
    if (rst_trig !== 1'b1 || sys_reset !== 1'b1) begin miscompares++;
      $display("FAIL fall_trigger got sr=%b rt=%b want 1/1",
               sys_reset, rst_trig); end
    while (sys_reset === 1'b1 && cyc < 600) begin
      if (ce[0]) ticks++;
      if (ticks == 10 && !retrig) begin
        req_rise = 3'b111;
        retrig   = 1;
      end
      step();
      cyc++;
      if (rst_trig) rts++;
    end
    vectors++;
    if (sys_reset !== 1'b0) begin miscompares++;
      $display("FAIL hold_timeout got sr=%b want 0 after %0d", sys_reset, cyc); end
    vectors++;
    if (ticks != 26) begin miscompares++;
      $display("FAIL retrig_hold_ticks got %0d want 26", ticks); end
    vectors++;
    if (rts != 1) begin miscompares++;
      $display("FAIL retrig_pulses got %0d want 1", rts); end
    req_fall = 1'b1;
    step();
  endtask

  task automatic test_no_timeout();
    int c0 = 0, cyc = 0;
    ch_en    = 3'b110;
    req_fall = 1'b0;
    step();
    for (int n = 0; n < 120; n++) begin
      step();
      if (ce[0]) c0++;
    end
    vectors++;
    if (sys_reset !== 1'b1 || c0 != 0) begin miscompares++;
      $display("FAIL stalled_hold got sr=%b ce0=%0d want 1/0", sys_reset, c0); end
    req_fall = 1'b1;
    ch_en    = 3'b111;
    while (sys_reset === 1'b1 && cyc < 200) begin
      step();
      cyc++;
    end
    vectors++;
    if (sys_reset !== 1'b0) begin miscompares++;
      $display("FAIL resume_release got sr=%b want 0", sys_reset); end
  endtask

  task automatic test_sync_clr();
    int first0 = 0, c1 = 0;
    for (int n = 0; n < 7; n++) step();
    ch_en    = 3'b101;
    sync_clr = 1'b1;
    step();
    vectors++;
    if (ce !== 3'b000) begin miscompares++;
      $display("FAIL sync_clr_ce got %b want 000", ce); end
    sync_clr = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (ce[0] && first0 == 0) first0 = n;
      if (ce[1]) c1++;
    end
    vectors++;
    if (first0 != 4) begin miscompares++;
      $display("FAIL realign_ce0 got %0d want 4", first0); end
    vectors++;
    if (c1 != 0) begin miscompares++;
      $display("FAIL frozen_ce1 got %0d want 0", c1); end
    ch_en = 3'b111;
    ch_inc[15:8] = 8'd200;
    for (int n = 0; n < 64; n++) step();
  endtask

  initial begin
    reset    = 1'b1;
    ch_inc   = '0;
    ch_en    = '0;
    sync_clr = 1'b0;
    req_rise = '0;
    req_fall = 1'b1;
    m_ce     = '0;
    m_hold   = 1;
    m_cnt    = 0;
    m_prise  = '0;
    m_pfall  = 1'b1;
    for (int i = 0; i < NCH; i++) m_acc[i] = 0;
    #2;
    test_reset();
    test_power_on();
    test_full_rate();
    test_retrigger();
    test_no_timeout();
    test_sync_clr();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
